// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states, prefix bytes
// and the keyboard response codes that are never reported as key events.
package ps2_keyboard_rx_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_OVERRUN0 = 8'h00;
    localparam logic [7:0] PS2_OVERRUN1 = 8'hFF;

    // Keyboard status/response bytes: dropped, and any pending prefix is discarded.
    function automatic logic is_response(input logic [7:0] b);
        return b inside {PS2_BAT_OK, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVERRUN0, PS2_OVERRUN1};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 line; the level output only
// follows the input after FILTER consecutive samples that differ from it.
module ps2_line_filter #(
    parameter int unsigned FILTER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line};
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: filters the lines, reassembles 11-bit frames on clock
// falls, and folds E0/F0 prefixes into single key events.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int unsigned FILTER  = 4,
    parameter int unsigned TIMEOUT = 8191
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_error,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       key_strobe
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic clk_f, data_f, clk_prev_q, fall;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clk_in),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_data_in),
        .level (data_f)
    );

    assign fall = clk_prev_q & ~clk_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_strobe_q, rx_strobe_d, rx_error_q, rx_error_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d, key_rel_q, key_rel_d, key_strobe_q, key_strobe_d;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tcnt_d      = tcnt_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        rx_error_d  = 1'b0;

        if (state_q == StIdle || fall) begin
            tcnt_d = '0;
        end else if (tcnt_q != TW'(TIMEOUT)) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_f) begin
                        state_d  = StData;
                        bitcnt_d = '0;
                    end
                end
                StData: begin
                    shift_d  = {data_f, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_f;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if ((^{shift_q, parity_q}) && data_f) begin
                        rx_byte_d   = shift_q;
                        rx_strobe_d = 1'b1;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != StIdle && tcnt_q == TW'(TIMEOUT)) begin
            state_d    = StIdle;
            rx_error_d = 1'b1;
        end
    end

    // Prefix decoder works on the registered byte, one cycle behind rx_strobe.
    always_comb begin
        ext_d        = ext_q;
        rel_d        = rel_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_rel_d    = key_rel_q;
        key_strobe_d = 1'b0;

        if (rx_error_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (rx_strobe_q) begin
            if (rx_byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_REL) begin
                rel_d = 1'b1;
            end else if (rx_byte_q == PS2_PAUSE) begin
                ext_d = ext_q;
            end else if (is_response(rx_byte_q)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                key_code_d   = rx_byte_q;
                key_ext_d    = ext_q;
                key_rel_d    = rel_q;
                key_strobe_d = 1'b1;
                ext_d        = 1'b0;
                rel_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_q   <= 1'b1;
            state_q      <= StIdle;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tcnt_q       <= '0;
            rx_byte_q    <= '0;
            rx_strobe_q  <= 1'b0;
            rx_error_q   <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_rel_q    <= 1'b0;
            key_strobe_q <= 1'b0;
        end else begin
            clk_prev_q   <= clk_f;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tcnt_q       <= tcnt_d;
            rx_byte_q    <= rx_byte_d;
            rx_strobe_q  <= rx_strobe_d;
            rx_error_q   <= rx_error_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_rel_q    <= key_rel_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign rx_byte      = rx_byte_q;
    assign rx_strobe    = rx_strobe_q;
    assign rx_error     = rx_error_q;
    assign key_code     = key_code_q;
    assign key_extended = key_ext_q;
    assign key_released = key_rel_q;
    assign key_strobe   = key_strobe_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames at 80 core clocks per bit
// and checks decoded bytes, key events, errors and timeouts.
module tb_ps2_keyboard_rx;

    localparam int HALF    = 40;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 8191;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_data_in = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_error;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       key_strobe;

    ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .rx_byte      (rx_byte),
        .rx_strobe    (rx_strobe),
        .rx_error     (rx_error),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_released (key_released),
        .key_strobe   (key_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rx_cnt = 0, err_cnt = 0, key_cnt = 0;
    int last_rx_cyc = 0, last_key_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rx_strobe) begin
            rx_cnt++;
            last_rx_cyc = cyc;
        end
        if (rx_error) err_cnt++;
        if (key_strobe) begin
            key_cnt++;
            last_key_cyc = cyc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_parity);
        return {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    endfunction

    // Sends frame bits first..last; glitch_bit gets a short low pulse on the clock line.
    task automatic send_bits(input logic [10:0] f, input int first, input int last,
                             input int glitch_bit);
        for (int i = first; i <= last; i++) begin
            ps2_data_in = f[i];
            cycles(HALF / 2);
            if (i == glitch_bit) begin
                ps2_clk_in = 1'b0;
                cycles(FILTER - 1);
                ps2_clk_in = 1'b1;
            end
            cycles(HALF / 2);
            ps2_clk_in = 1'b0;
            cycles(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0), 0, 10, -1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cycles(3);
        checks++;
        if ({rx_byte, rx_strobe, rx_error, key_code, key_extended, key_released, key_strobe} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", {rx_byte, rx_strobe, rx_error, key_code,
                     key_extended, key_released, key_strobe});
        end
        reset = 1'b0;
        cycles(20);
        checks++;
        if ({rx_byte, rx_strobe, rx_error, key_code, key_extended, key_released, key_strobe} !== 20'd0) begin
            failures++;
            $display("FAIL idle_outputs got %h want 0", {rx_byte, rx_strobe, rx_error, key_code,
                     key_extended, key_released, key_strobe});
        end
    endtask

    task automatic test_single_key;
        int rx0 = rx_cnt, e0 = err_cnt, k0 = key_cnt;
        send_byte(8'h1C);
        checks++;
        if (rx_cnt - rx0 !== 1) begin failures++; $display("FAIL single_rx_count got %0d want 1", rx_cnt - rx0); end
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL single_err_count got %0d want 0", err_cnt - e0); end
        checks++;
        if (rx_byte !== 8'h1C) begin failures++; $display("FAIL single_rx_byte got %h want 1c", rx_byte); end
        checks++;
        if (key_cnt - k0 !== 1) begin failures++; $display("FAIL single_key_count got %0d want 1", key_cnt - k0); end
        checks++;
        if ({key_code, key_extended, key_released} !== {8'h1C, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_key got %h/%b/%b want 1c/0/0", key_code, key_extended, key_released);
        end
        checks++;
        if (last_key_cyc - last_rx_cyc !== 1) begin
            failures++;
            $display("FAIL single_key_lag got %0d want 1", last_key_cyc - last_rx_cyc);
        end
    endtask

    task automatic test_drop;
        int k0 = key_cnt;
        send_byte(8'hF0);
        send_byte(8'hAA);
        send_byte(8'h1C);
        checks++;
        if (key_cnt - k0 !== 1) begin failures++; $display("FAIL drop_key_count got %0d want 1", key_cnt - k0); end
        checks++;
        if ({key_code, key_extended, key_released} !== {8'h1C, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL drop_key got %h/%b/%b want 1c/0/0", key_code, key_extended, key_released);
        end
    endtask

    task automatic test_prefix;
        int rx0 = rx_cnt, k0 = key_cnt;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (rx_cnt - rx0 !== 3) begin failures++; $display("FAIL prefix_rx_count got %0d want 3", rx_cnt - rx0); end
        checks++;
        if (key_cnt - k0 !== 1) begin failures++; $display("FAIL prefix_key_count got %0d want 1", key_cnt - k0); end
        checks++;
        if ({key_code, key_extended, key_released} !== {8'h75, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL prefix_key got %h/%b/%b want 75/1/1", key_code, key_extended, key_released);
        end
        send_byte(8'h29);
        checks++;
        if (key_cnt - k0 !== 2) begin failures++; $display("FAIL plain_key_count got %0d want 2", key_cnt - k0); end
        checks++;
        if ({key_code, key_extended, key_released} !== {8'h29, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL plain_key got %h/%b/%b want 29/0/0", key_code, key_extended, key_released);
        end
    endtask

    task automatic test_parity_error;
        int rx0, e0, k0;
        send_byte(8'hF0);
        rx0 = rx_cnt; e0 = err_cnt; k0 = key_cnt;
        send_bits(frame(8'h1C, 1'b1), 0, 10, -1);
        checks++;
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err_count got %0d want 1", err_cnt - e0); end
        checks++;
        if (rx_cnt - rx0 !== 0) begin failures++; $display("FAIL parity_rx_count got %0d want 0", rx_cnt - rx0); end
        checks++;
        if (rx_byte !== 8'hF0) begin failures++; $display("FAIL parity_hold_byte got %h want f0", rx_byte); end
        send_byte(8'h29);
        checks++;
        if (rx_byte !== 8'h29) begin failures++; $display("FAIL parity_next_byte got %h want 29", rx_byte); end
        checks++;
        if (key_cnt - k0 !== 1) begin failures++; $display("FAIL parity_key_count got %0d want 1", key_cnt - k0); end
        checks++;
        if ({key_code, key_released} !== {8'h29, 1'b0}) begin
            failures++;
            $display("FAIL parity_flag_clear got %h/%b want 29/0", key_code, key_released);
        end
    endtask

    task automatic test_timeout;
        int rx0 = rx_cnt, e0 = err_cnt;
        send_bits(frame(8'hFF, 1'b0), 0, 5, -1);
        cycles(TIMEOUT - 500);
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL timeout_early got %0d want 0", err_cnt - e0); end
        cycles(502 + FILTER + 10);
        checks++;
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err_count got %0d want 1", err_cnt - e0); end
        send_byte(8'h29);
        checks++;
        if (rx_cnt - rx0 !== 1) begin failures++; $display("FAIL timeout_rx_count got %0d want 1", rx_cnt - rx0); end
        checks++;
        if (rx_byte !== 8'h29) begin failures++; $display("FAIL timeout_next_byte got %h want 29", rx_byte); end
        checks++;
        if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err_after got %0d want 1", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int rx0 = rx_cnt, e0 = err_cnt;
        send_bits(frame(8'h1C, 1'b0), 0, 10, 3);
        checks++;
        if (rx_cnt - rx0 !== 1) begin failures++; $display("FAIL glitch_rx_count got %0d want 1", rx_cnt - rx0); end
        checks++;
        if (rx_byte !== 8'h1C) begin failures++; $display("FAIL glitch_rx_byte got %h want 1c", rx_byte); end
        checks++;
        if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err_count got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_reset_midframe;
        int rx0, k0;
        send_bits(frame(8'h1C, 1'b0), 0, 4, -1);
        reset = 1'b1;
        cycles(1);
        checks++;
        if ({rx_byte, rx_strobe, rx_error, key_code, key_extended, key_released, key_strobe} !== 20'd0) begin
            failures++;
            $display("FAIL midreset_outputs got %h want 0", {rx_byte, rx_strobe, rx_error, key_code,
                     key_extended, key_released, key_strobe});
        end
        reset = 1'b0;
        rx0 = rx_cnt; k0 = key_cnt;
        send_bits(frame(8'h1C, 1'b0), 5, 10, -1);
        cycles(TIMEOUT + 100);
        checks++;
        if (rx_cnt - rx0 !== 0) begin failures++; $display("FAIL midreset_rx_count got %0d want 0", rx_cnt - rx0); end
        checks++;
        if (key_cnt - k0 !== 0) begin failures++; $display("FAIL midreset_key_count got %0d want 0", key_cnt - k0); end
        send_byte(8'h1C);
        checks++;
        if (rx_byte !== 8'h1C) begin failures++; $display("FAIL midreset_next_byte got %h want 1c", rx_byte); end
        checks++;
        if (key_cnt - k0 !== 1 || key_code !== 8'h1C) begin
            failures++;
            $display("FAIL midreset_next_key got %0d/%h want 1/1c", key_cnt - k0, key_code);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_drop();
        test_prefix();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
